// File: rtl/jesd204b_pkg.sv
// Shared encodings and defaults for the JESD204B link controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jesd204b_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] mf_idx_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CGS  = 2'd1;
    localparam state_t ST_ILAS = 2'd2;
    localparam state_t ST_DATA = 2'd3;

    // ilas_mf_idx is two bits wide, so at most four ILAS multiframes are representable
    localparam int ILAS_MULTIFRAMES_DEF = 4;
    localparam int SYNC_FILTER_DEF      = 4;

    // True in the states where the lanes are past code-group sync
    function automatic logic lane_aligned(state_t st);
        return (st == ST_ILAS) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/jesd204b_link_ctrl_if.sv
// Link-control bundle: bring-up inputs plus TX mode selects and status.
// Latency: n/a (wires only).
// Backpressure: none; SYNC~ is the receiver's only way to push back.
interface jesd204b_link_ctrl_if
    import jesd204b_pkg::*;
#(
    parameter int CNT_WIDTH = 8
);
    logic                 link_enable;
    logic                 lmfc_edge;
    logic                 sync_n;
    state_t               state;
    logic                 send_cgs;
    logic                 send_ilas;
    logic                 send_data;
    mf_idx_t              ilas_mf_idx;
    logic                 ilas_cfg_mf;
    logic                 link_up;
    logic [CNT_WIDTH-1:0] resync_count;

    // Environment side: drives enable, LMFC timing and SYNC~
    modport master (
        output link_enable, lmfc_edge, sync_n,
        input  state, send_cgs, send_ilas, send_data,
        input  ilas_mf_idx, ilas_cfg_mf, link_up, resync_count
    );

    // Controller side
    modport slave (
        input  link_enable, lmfc_edge, sync_n,
        output state, send_cgs, send_ilas, send_data,
        output ilas_mf_idx, ilas_cfg_mf, link_up, resync_count
    );
endinterface

// File: rtl/jesd204b_link_ctrl_sync_filter.sv
// SYNC~ debounce: flags a resync request after SYNC_FILTER consecutive low cycles.
// Latency: req is combinational on the cycle the low run reaches SYNC_FILTER.
// Backpressure: none; clear restarts the run count.
module jesd204b_sync_filter
    import jesd204b_pkg::*;
#(
    parameter int SYNC_FILTER = SYNC_FILTER_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sync_n,
    output logic req
);
    localparam int             CW   = $clog2(SYNC_FILTER + 1);
    localparam logic [CW-1:0]  LAST = CW'(SYNC_FILTER - 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the low cycles seen before this one, so the current low completes the run
    assign req = !sync_n && (r_cnt == LAST);

    // Count consecutive lows; any high, a clear or reset restarts the run
    always_ff @(posedge clk) begin
        if (reset || clear || sync_n) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/jesd204b_link_ctrl.sv
// JESD204B TX link bring-up FSM: IDLE -> CGS -> ILAS -> DATA with SYNC~ resync.
// Latency: all outputs registered, reflecting the state entered at the last edge.
// Backpressure: SYNC~ held low for SYNC_FILTER cycles drops the link back to CGS.
module jesd204b_link_ctrl
    import jesd204b_pkg::*;
#(
    parameter int ILAS_MULTIFRAMES = ILAS_MULTIFRAMES_DEF,
    parameter int SYNC_FILTER      = SYNC_FILTER_DEF,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                reset,
    jesd204b_link_ctrl_if.slave lnk
);
    localparam mf_idx_t LAST_MF = 2'(ILAS_MULTIFRAMES - 1);

    state_t               r_state;
    logic                 r_sync_ok;
    mf_idx_t              r_mf_idx;
    logic                 r_send_cgs;
    logic                 r_send_ilas;
    logic                 r_send_data;
    logic                 r_cfg_mf;
    logic                 r_link_up;
    logic [CNT_WIDTH-1:0] r_resync_cnt;

    state_t               w_state_nxt;
    mf_idx_t              w_mf_nxt;
    logic                 w_state_chg;
    logic                 w_filt_req;
    logic                 w_filt_clr;

    // Run count only while aligned; restart it on every state change
    assign w_filt_clr = w_state_chg || !lane_aligned(r_state);

    jesd204b_sync_filter #(
        .SYNC_FILTER (SYNC_FILTER)
    ) u_sync_filter (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_filt_clr),
        .sync_n (lnk.sync_n),
        .req    (w_filt_req)
    );

    // Next-state decode; dropping link_enable overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!lnk.link_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CGS;
                ST_CGS: begin
                    // sync_ok is last cycle's view, so a SYNC~ rise on the edge itself is too late
                    if (lnk.lmfc_edge && r_sync_ok && lnk.sync_n) begin
                        w_state_nxt = ST_ILAS;
                    end
                end
                ST_ILAS: begin
                    if (w_filt_req) begin
                        w_state_nxt = ST_CGS;
                    end else if (lnk.lmfc_edge && (r_mf_idx == LAST_MF)) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_filt_req) begin
                        w_state_nxt = ST_CGS;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_state_chg = (w_state_nxt != r_state);

    // Multiframe index: zero outside ILAS and on entry, steps on each LMFC edge inside
    always_comb begin
        w_mf_nxt = '0;
        if (!w_state_chg && (r_state == ST_ILAS)) begin
            w_mf_nxt = lnk.lmfc_edge ? r_mf_idx + 1'b1 : r_mf_idx;
        end
    end

    // State, registered outputs and sync_ok tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sync_ok   <= 1'b0;
            r_mf_idx    <= '0;
            r_send_cgs  <= 1'b0;
            r_send_ilas <= 1'b0;
            r_send_data <= 1'b0;
            r_cfg_mf    <= 1'b0;
            r_link_up   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mf_idx    <= w_mf_nxt;
            r_send_cgs  <= (w_state_nxt == ST_CGS);
            r_send_ilas <= (w_state_nxt == ST_ILAS);
            r_send_data <= (w_state_nxt == ST_DATA);
            r_cfg_mf    <= (w_state_nxt == ST_ILAS) && (w_mf_nxt == 2'd1);
            r_link_up   <= (w_state_nxt == ST_DATA);
            if (w_state_chg) begin
                r_sync_ok <= 1'b0;
            end else if (r_state == ST_CGS) begin
                r_sync_ok <= lnk.sync_n;
            end
        end
    end

    // Saturating count of resyncs that knocked the link out of DATA
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resync_cnt <= '0;
        end else if ((r_state == ST_DATA) && (w_state_nxt == ST_CGS) && (r_resync_cnt != '1)) begin
            r_resync_cnt <= r_resync_cnt + 1'b1;
        end
    end

    assign lnk.state        = r_state;
    assign lnk.send_cgs     = r_send_cgs;
    assign lnk.send_ilas    = r_send_ilas;
    assign lnk.send_data    = r_send_data;
    assign lnk.ilas_mf_idx  = r_mf_idx;
    assign lnk.ilas_cfg_mf  = r_cfg_mf;
    assign lnk.link_up      = r_link_up;
    assign lnk.resync_count = r_resync_cnt;
endmodule

// File: tb/tb_jesd204b_link_ctrl.sv
// Scoreboard bench for jesd204b_link_ctrl: behavioural model predicts every cycle's outputs.
// Latency: model result for a cycle is checked #1 after the edge that registers it.
// Backpressure: n/a.
module tb_jesd204b_link_ctrl;
    import jesd204b_pkg::*;

    localparam int MF     = 4;
    localparam int SF     = 4;
    localparam int CW     = 8;
    localparam int RC_MAX = 255;

    typedef struct packed {
        logic [1:0]    st;
        logic          cgs;
        logic          ilas;
        logic          data;
        logic [1:0]    mf;
        logic          cfg;
        logic          up;
        logic [CW-1:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jesd204b_link_ctrl_if #(.CNT_WIDTH(CW)) lnk ();

    jesd204b_link_ctrl #(
        .ILAS_MULTIFRAMES (MF),
        .SYNC_FILTER      (SF),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lnk   (lnk.slave)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];

    // Reference model: link phase 0..3, plus bookkeeping from the written rules
    int m_st = 0, m_ok = 0, m_low = 0, m_mf = 0, m_rc = 0;

    function automatic void model_step(logic r, logic en, logic lmfc, logic sn);
        int nxt;
        if (r) begin
            m_st = 0; m_ok = 0; m_low = 0; m_mf = 0; m_rc = 0;
            return;
        end
        nxt = m_st;
        if (!en)                                nxt = 0;
        else if (m_st == 0)                     nxt = 1;
        else if (m_st == 1) begin
            if (lmfc && m_ok != 0 && sn)        nxt = 2;
        end else begin
            if (!sn && (m_low + 1) >= SF)       nxt = 1;
            else if (m_st == 2 && lmfc && m_mf == MF - 1) nxt = 3;
        end
        if (m_st == 3 && nxt == 1 && m_rc < RC_MAX) m_rc = m_rc + 1;
        if (nxt != m_st) begin
            m_ok = 0; m_low = 0; m_mf = 0;
        end else begin
            if (m_st == 1) m_ok = sn ? 1 : 0;
            if (m_st >= 2) m_low = sn ? 0 : m_low + 1;
            if (m_st == 2 && lmfc) m_mf = m_mf + 1;
        end
        m_st = nxt;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.st   = 2'(m_st);
        e.cgs  = (m_st == 1);
        e.ilas = (m_st == 2);
        e.data = (m_st == 3);
        e.mf   = (m_st == 2) ? 2'(m_mf) : 2'd0;
        e.cfg  = (m_st == 2) && (m_mf == 1);
        e.up   = (m_st == 3);
        e.rc   = CW'(m_rc);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict its outcome, return #1 after the edge
    task automatic step(input logic r, input logic en, input logic lmfc, input logic sn);
        @(negedge clk);
        reset           = r;
        lnk.link_enable = en;
        lnk.lmfc_edge   = lmfc;
        lnk.sync_n      = sn;
        model_step(r, en, lmfc, sn);
        expq.push_back(model_exp());
        @(posedge clk);
        #1;
    endtask

    // Periodic LMFC generator
    int per   = 21;
    int phase = 1;

    task automatic tick(input logic en, input logic sn);
        logic lmfc;
        lmfc  = (phase == 0);
        phase = (phase + 1) % per;
        step(1'b0, en, lmfc, sn);
    endtask

    task automatic bring_to_data(input string nm);
        int reached = 0;
        for (int i = 0; i < 8 * per + 20; i++) begin
            if (lnk.state == ST_DATA) begin
                reached = 1;
                break;
            end
            tick(1'b1, 1'b1);
        end
        chk(nm, reached, 1);
    endtask

    // Monitor: every cycle after reset activity has a prediction waiting
    exp_t act_o, exp_o;
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            exp_o        = expq.pop_front();
            act_o.st     = lnk.state;
            act_o.cgs    = lnk.send_cgs;
            act_o.ilas   = lnk.send_ilas;
            act_o.data   = lnk.send_data;
            act_o.mf     = lnk.ilas_mf_idx;
            act_o.cfg    = lnk.ilas_cfg_mf;
            act_o.up     = lnk.link_up;
            act_o.rc     = lnk.resync_count;
            total++;
            if (act_o !== exp_o) begin
                bad++;
                $display("FAIL cycle_out t=%0t actual=%h required=%h", $time, act_o, exp_o);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cfg_cycles, n, reached, burst;
        logic r, en, lm, sn;

        reset           = 1'b1;
        lnk.link_enable = 1'b0;
        lnk.lmfc_edge   = 1'b0;
        lnk.sync_n      = 1'b1;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_state", int'(lnk.state), 0);
        chk("reset_rc", int'(lnk.resync_count), 0);

        // Bring-up: SYNC~ low 50 cycles then high; count config-multiframe cycles
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0);
        chk("cgs_after_enable", int'(lnk.state), 1);
        cfg_cycles = 0;
        reached    = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b1);
            if (lnk.ilas_cfg_mf) cfg_cycles++;
            if (lnk.state == ST_DATA) begin
                reached = 1;
                break;
            end
        end
        chk("bringup_reached", reached, 1);
        chk("cfg_mf_cycles", cfg_cycles, 21);
        chk("link_up", int'(lnk.link_up), 1);

        // SYNC~ rising on the LMFC edge itself: ILAS a full period later
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        for (int i = 0; i < per && phase != 0; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b1);
            n++;
            if (lnk.state == ST_ILAS) break;
        end
        chk("samecycle_delay", n, 21);
        bring_to_data("bringup_2");

        // Short glitch is ignored
        repeat (3) tick(1'b1, 1'b0);
        repeat (5) tick(1'b1, 1'b1);
        chk("glitch_state", int'(lnk.state), 3);
        chk("glitch_rc", int'(lnk.resync_count), 0);

        // Filter-length low run resyncs
        repeat (3) tick(1'b1, 1'b0);
        chk("resync_3low_state", int'(lnk.state), 3);
        tick(1'b1, 1'b0);
        chk("resync_state", int'(lnk.state), 1);
        chk("resync_rc", int'(lnk.resync_count), 1);

        // Disable in the middle of ILAS
        reached = 0;
        for (int i = 0; i < 8 * per; i++) begin
            tick(1'b1, 1'b1);
            if (lnk.state == ST_ILAS && lnk.ilas_mf_idx == 2'd2) begin
                reached = 1;
                break;
            end
        end
        chk("mid_ilas_reached", reached, 1);
        tick(1'b0, 1'b1);
        chk("disable_state", int'(lnk.state), 0);
        chk("disable_sends", int'({lnk.send_cgs, lnk.send_ilas, lnk.send_data}), 0);
        chk("disable_rc_kept", int'(lnk.resync_count), 1);

        // Reset while in DATA
        bring_to_data("bringup_3");
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_data_state", int'(lnk.state), 0);
        chk("rst_data_up", int'(lnk.link_up), 0);
        chk("rst_data_rc", int'(lnk.resync_count), 0);
        chk("rst_data_sends", int'({lnk.send_cgs, lnk.send_ilas, lnk.send_data}), 0);

        // Randomised traffic checked cycle by cycle against the model
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 199) != 0);
            lm = ($urandom_range(0, 9) == 0);
            if (burst > 0) begin
                sn = 1'b0;
                burst--;
            end else if ($urandom_range(0, 29) == 0) begin
                sn    = 1'b0;
                burst = $urandom_range(0, 6);
            end else begin
                sn = 1'b1;
            end
            step(r, en, lm, sn);
        end

        // Saturation: 300 resyncs out of DATA on a short LMFC period
        per   = 5;
        phase = 1;
        for (int k = 0; k < 300; k++) begin
            bring_to_data("sat_bringup");
            repeat (4) tick(1'b1, 1'b0);
        end
        chk("rc_saturated", int'(lnk.resync_count), RC_MAX);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
